inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the synchronous-read instruction memory.
- That memory registers `Mem[address[6:0]]` onto `inst` at every posedge, with a fixed 1-cycle latency and no enable.
- This block owns the program counter, drives the memory address, pairs each returned word with its PC, and hands it to decode over a valid/ready handshake.
- It absorbs decode stalls with a 1-entry skid buffer and services branch redirects from execute with squash of wrong-path words.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0, word address fetched first after reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  permit new requests; 0 freezes issue without losing in-flight or buffered words.
- mem_addr  out  XLEN  word address to instruction memory.
- mem_inst  in  XLEN  memory data; corresponds to mem_addr of the previous cycle.
- redirect_valid  in  1  execute-stage redirect (taken branch/jump).
- redirect_target  in  XLEN  word address of redirect.
- dec_valid  out  1  dec_inst/dec_pc valid.
- dec_ready  in  1  decode accepts this cycle.
- dec_inst  out  XLEN  instruction word.
- dec_pc  out  XLEN  word address of dec_inst.

Behaviour:
- State registers:
  - pc: next address to request.
  - req_valid, req_pc: the previous cycle's address was a live request; its data is on mem_inst now.
  - skid: sk_valid, sk_inst, sk_pc.
- Addressing is word-granular: sequential next = pc+1, wraps modulo 2^XLEN. The memory itself uses only the low 7 bits.
- Output mux:
  - If sk_valid: present sk_inst/sk_pc.
  - Else: present mem_inst/req_pc.
  - dec_valid = (sk_valid | req_valid) & ~redirect_valid.
- Handshake:
  - A transfer occurs when dec_valid & dec_ready.
  - dec_inst/dec_pc must be held stable while dec_valid=1 and dec_ready=0.
- Issue condition: issue = fetch_en & (dec_ready | (~sk_valid & ~req_valid)). This guarantees at most one unconsumed word exists, so the skid never overflows.
- mem_addr = redirect_valid ? redirect_target : pc (combinational).
- Normal cycle (no redirect):
  - If issue: pc <= pc+1; req_pc <= pc; req_valid <= 1.
  - Else: req_valid <= 0; pc holds.
  - If req_valid & ~sk_valid & ~dec_ready: the word moves into the skid (sk_valid <= 1).
  - If sk_valid & dec_ready: the skid drains (sk_valid <= 0).
- Redirect cycle (redirect_valid=1):
  - Squash: req_valid and sk_valid are discarded; dec_valid=0 this cycle.
  - Target is fetched the same cycle: if fetch_en, req_pc <= target, req_valid <= 1, pc <= target+1; otherwise req_valid <= 0 and pc <= target.
  - First target word is visible on dec_* the next cycle (1-cycle redirect penalty).
- Redirect while decode is stalled: the squash still takes effect; redirect has priority over every other event.
- fetch_en low: in-flight word and skid still drain normally; no new requests.
- Reset (any cycle, including mid-stall or mid-redirect):
  - pc <= RESET_PC; req_valid, sk_valid <= 0; sk_inst, sk_pc, req_pc <= 0.
  - dec_valid=0 for the reset cycle and the following cycle.
  - The first word arrives 2 cycles after reset deasserts if fetch_en=1.
- Throughput is 1 instruction/cycle with dec_ready held high.

Optional Feature:
- Macro INST_FETCH_STATS_EN.
- When defined, adds outputs stat_fetched (32) and stat_squashed (32):
  - stat_fetched increments on every dec transfer.
  - stat_squashed increments once per redirect cycle in which a valid word (req_valid or sk_valid) was discarded.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds XLEN, RESET_PC, NOP encoding 32'h0000_0020, and a fetch_pkt_t struct {inst, pc}.
- One sub-module, fetch_skid_buf: 1-entry buffer with load/drain/flush of fetch_pkt_t.
- The PC/issue logic stays in the top module.

Test Plan:
- Reset release, fetch_en=1, dec_ready=1, memory Mem[0]=32'h00802820, Mem[1]=32'h00252820 -> dec_valid first high 2 cycles after reset; dec_pc 0,1,2,... on consecutive cycles; dec_inst matches Mem[pc].
- dec_ready low for 3 cycles while dec_pc=4 is presented -> dec_inst/dec_pc stay at pc 4 throughout; after ready returns, pcs 4,5,6 delivered with no gap or duplicate.
- Redirect to 2 while dec_pc=10 is presented -> dec_valid=0 that cycle; next cycle dec_pc=2; no word from pc 11 ever transfers.
- Redirect to 0 while the skid is full and dec_ready=0 -> the skid word is discarded; the next transfer has dec_pc=0.
- Reset asserted while the skid is full -> dec_valid=0; after release the sequence restarts at dec_pc=0.
- With INST_FETCH_STATS_EN: 8 transfers and 2 squashing redirects -> stat_fetched=8, stat_squashed=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0020;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Word-granular sequential successor; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch bus: instruction-memory address/data, execute redirect and decode handshake.
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output mem_addr, dec_valid, dec_inst, dec_pc,
    input  mem_inst, redirect_valid, redirect_target, dec_ready
  );

  modport slave (
    input  mem_addr, dec_valid, dec_inst, dec_pc,
    output mem_inst, redirect_valid, redirect_target, dec_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched {inst, pc} packet; flush beats load beats drain.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       drain,
  input  logic       flush,
  input  fetch_pkt_t pkt_in,
  output logic       valid,
  output fetch_pkt_t pkt
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pkt   <= pkt_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC owner / fetch initiator for a 1-cycle synchronous instruction memory.
// Optional counters stat_fetched/stat_squashed exist when INST_FETCH_STATS_EN is defined.
module inst_fetch_unit #(
  parameter logic [fetch_pkg::XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_en,
`ifdef INST_FETCH_STATS_EN
  output logic [31:0]               stat_fetched,
  output logic [31:0]               stat_squashed,
`endif
  inst_fetch_unit_if.master         bus
);
  import fetch_pkg::*;

  logic [XLEN-1:0] pc;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic            sk_valid;
  fetch_pkt_t      sk_pkt;
  fetch_pkt_t      live_pkt;
  fetch_pkt_t      out_pkt;
  logic            issue;
  logic            sk_load;
  logic            sk_drain;

  // Never more than one unconsumed word: stop issuing while one is stalled.
  assign issue    = fetch_en & (bus.dec_ready | (~sk_valid & ~req_valid));
  assign sk_load  = req_valid & ~sk_valid & ~bus.dec_ready & ~bus.redirect_valid;
  assign sk_drain = sk_valid & bus.dec_ready;

  assign live_pkt = '{inst: bus.mem_inst, pc: req_pc};
  assign out_pkt  = sk_valid ? sk_pkt : live_pkt;

  assign bus.mem_addr  = bus.redirect_valid ? bus.redirect_target : pc;
  assign bus.dec_valid = (sk_valid | req_valid) & ~bus.redirect_valid & ~reset;
  assign bus.dec_inst  = out_pkt.inst;
  assign bus.dec_pc    = out_pkt.pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (bus.redirect_valid) begin
      if (fetch_en) begin
        req_valid <= 1'b1;
        req_pc    <= bus.redirect_target;
        pc        <= pc_inc(bus.redirect_target);
      end else begin
        req_valid <= 1'b0;
        pc        <= bus.redirect_target;
      end
    end else if (issue) begin
      req_valid <= 1'b1;
      req_pc    <= pc;
      pc        <= pc_inc(pc);
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clock  (clock),
    .reset  (reset),
    .load   (sk_load),
    .drain  (sk_drain),
    .flush  (bus.redirect_valid),
    .pkt_in (live_pkt),
    .valid  (sk_valid),
    .pkt    (sk_pkt)
  );

`ifdef INST_FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched  <= '0;
      stat_squashed <= '0;
    end else begin
      if (bus.dec_valid & bus.dec_ready)
        stat_fetched <= sat_inc(stat_fetched);
      if (bus.redirect_valid & (req_valid | sk_valid))
        stat_squashed <= sat_inc(stat_squashed);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: per-cycle vector table plus a transfer scoreboard.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_en = 1'b1;
  logic [31:0] mem [128];

`ifdef INST_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_squashed;
`endif

  inst_fetch_unit_if bus ();

  inst_fetch_unit dut (
    .clock         (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
`ifdef INST_FETCH_STATS_EN
    .stat_fetched  (stat_fetched),
    .stat_squashed (stat_squashed),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_inst <= mem[bus.mem_addr[6:0]];

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic        sq;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_fetched = 0;
  int          exp_squashed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic rdy, input logic rv,
                     input logic [31:0] tgt, input logic ev, input logic [31:0] epc,
                     input logic sq);
    vecs.push_back('{rst, en, rdy, rv, tgt, ev, epc, sq});
  endtask

  // Scoreboard pop on every transfer, plus hold-stability during stalls.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_inst;
  always @(negedge clk) begin
    if (prev_hold && !bus.redirect_valid && !reset) begin
      check("stall_valid", {31'd0, bus.dec_valid}, 32'd1);
      check("stall_pc", bus.dec_pc, prev_pc);
      check("stall_inst", bus.dec_inst, prev_inst);
    end
    if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got pc %h expected no transfer", bus.dec_pc);
      end else begin
        logic [31:0] epc;
        epc = sb.pop_front();
        check("xfer_pc", bus.dec_pc, epc);
        check("xfer_inst", bus.dec_inst, mem[epc[6:0]]);
      end
    end
    prev_hold = (bus.dec_valid === 1'b1) && (bus.dec_ready === 1'b0);
    prev_pc   = bus.dec_pc;
    prev_inst = bus.dec_inst;
  end

  initial begin
    logic [31:0] tgt;
    int budget;

    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    mem[0] = 32'h0080_2820;
    mem[1] = 32'h0025_2820;

    bus.dec_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    // rst en rdy rv tgt ev epc sq
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);                       // first cycle after release
    for (int p = 0; p < 4; p++) add(0, 1, 1, 0, 0, 1, p, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 1, 4, 0);   // stall on pc 4
    for (int p = 4; p < 10; p++) add(0, 1, 1, 0, 0, 1, p, 0);
    add(0, 1, 1, 1, 2, 0, 0, 1);                       // redirect while pc 10 shown
    add(0, 1, 1, 0, 0, 1, 2, 0);
    add(0, 1, 1, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0, 0, 1, 4, 0);                       // pc 4 goes to skid
    add(0, 1, 0, 1, 0, 0, 0, 1);                       // redirect with skid full
    for (int p = 0; p < 3; p++) add(0, 1, 1, 0, 0, 1, p, 0);
    add(0, 1, 0, 0, 0, 1, 3, 0);                       // pc 3 goes to skid
    add(1, 1, 0, 0, 0, 0, 0, 0);                       // reset with skid full
    add(0, 1, 1, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) add(0, 1, 1, 0, 0, 1, p, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0);                       // fetch_en low drains in-flight
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 4, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset               = vecs[i].rst;
      fetch_en            = vecs[i].en;
      bus.dec_ready       = vecs[i].rdy;
      bus.redirect_valid  = vecs[i].rv;
      bus.redirect_target = vecs[i].tgt;
      if (vecs[i].rst) begin
        exp_fetched  = 0;
        exp_squashed = 0;
      end
      if (vecs[i].ev && vecs[i].rdy) begin
        sb.push_back(vecs[i].epc);
        exp_fetched++;
      end
      if (vecs[i].sq) exp_squashed++;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'd0, bus.dec_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_pc", i), bus.dec_pc, vecs[i].epc);
        check($sformatf("vec%0d_inst", i), bus.dec_inst, mem[vecs[i].epc[6:0]]);
      end
    end

    // Redirect near the top of the address space, then random stalls and fetch gaps.
    tgt = 32'hFFFF_FFFE;
    for (int k = 0; k < 20; k++) sb.push_back(tgt + k);
    @(posedge clk);
    #1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    fetch_en            = 1'b1;
    bus.dec_ready       = 1'b1;
    exp_squashed++;                                    // pc 5 was in flight
    exp_fetched += 20;
    @(negedge clk);
    check("redir_wrap_valid", {31'd0, bus.dec_valid}, 32'd0);
    budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
      bus.dec_ready      = 1'($urandom_range(0, 1));
      fetch_en           = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #1;
      budget++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL random_drain: got %0d words left expected 0", sb.size());
    end

    @(posedge clk);
    #1;
    bus.dec_ready = 1'b0;
    fetch_en      = 1'b0;
    @(negedge clk);
`ifdef INST_FETCH_STATS_EN
    check("stat_fetched", stat_fetched, exp_fetched);
    check("stat_squashed", stat_squashed, exp_squashed);
`endif
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
